// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Request/response bundle between the core's execute/memory stage and the
// load/store unit.
//
// Signals:
//   req_valid        core -> LSU  request present
//   req_ready        LSU  -> core unit can accept a request
//   req_we           core -> LSU  1 = store, 0 = load
//   req_addr[31:0]   core -> LSU  byte address
//   req_wdata[31:0]  core -> LSU  store data (sub-word data in the low bits)
//   req_funct3[2:0]  core -> LSU  RISC-V funct3 (B, H, W, BU, HU)
//   resp_valid       LSU  -> core one-cycle completion pulse
//   resp_rdata[31:0] LSU  -> core load result, 0 for stores and faults
//   resp_misaligned  LSU  -> core fault flag, valid while resp_valid
//
// Modports: master = core side, slave = load/store unit side.
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready, resp_valid, resp_rdata, resp_misaligned
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Executes one RISC-V load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) at a time against
// a word-addressed data memory with combinational read and synchronous
// word-only write. Loads are lane-selected and sign/zero extended; sub-word
// stores are done as read-modify-write. Misaligned or illegal requests are
// answered with resp_misaligned and never reach memory.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   bus (slave)          request/response handshake, see load_store_unit_if
//   mem_address[31:0]    word-aligned memory address (0 when idle)
//   mem_write_data[31:0] merged store word (0 outside WRITE)
//   mem_w_en             memory write enable, one cycle per store
//   mem_read_data[31:0]  combinational memory read data
//   load_count, store_count, fault_count [15:0]
//                        saturating statistics, only with LSU_STATS_EN
//
// Parameter:
//   BYPASS_WORD_STORE    when 1, an aligned SW skips the READ phase
//
// Optional feature macro: LSU_STATS_EN (adds the statistics counters).
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter bit BYPASS_WORD_STORE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    load_store_unit_if.slave        bus,
    output logic [31:0]             mem_address,
    output logic [31:0]             mem_write_data,
    output logic                    mem_w_en,
    input  logic [31:0]             mem_read_data
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]             load_count,
    output logic [15:0]             store_count,
    output logic [15:0]             fault_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] lat_addr;
    logic        lat_we;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;
    logic [31:0] merged_word;
    logic [31:0] rdata_reg;
    logic        misaligned_reg;

    logic        handshake;
    logic        req_fault;
    logic        req_bypass;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;
    logic [31:0] store_merge;

    logic        ready_int;
    logic        resp_valid_int;

    // Ready is a pure function of state, so the handshake is derived from the
    // state directly rather than from the ready output.
    assign handshake = bus.req_valid && (state == IDLE);

    assign bus.req_ready       = ready_int;
    assign bus.resp_valid      = resp_valid_int;
    assign bus.resp_rdata      = rdata_reg;
    assign bus.resp_misaligned = misaligned_reg;

    // Classify the incoming request: alignment faults, reserved funct3 codes
    // and unsigned-store encodings all fault; an aligned SW may bypass READ.
    always_comb begin
        req_fault = 1'b0;
        case (bus.req_funct3)
            3'b000:  req_fault = 1'b0;
            3'b001:  req_fault = bus.req_addr[0];
            3'b010:  req_fault = (bus.req_addr[1:0] != 2'b00);
            3'b100:  req_fault = bus.req_we;
            3'b101:  req_fault = bus.req_we || bus.req_addr[0];
            default: req_fault = 1'b1;
        endcase
        req_bypass = BYPASS_WORD_STORE && bus.req_we && (bus.req_funct3 == 3'b010);
    end

    // Load lane selection and extension, plus store lane merge into the word
    // currently read from memory (untouched lanes keep their old contents).
    always_comb begin
        sel_byte   = mem_read_data[{lat_addr[1:0], 3'b000} +: 8];
        sel_half   = mem_read_data[{lat_addr[1], 4'b0000} +: 16];
        load_value = mem_read_data;
        case (lat_funct3)
            3'b000:  load_value = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_value = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_value = {24'd0, sel_byte};
            3'b101:  load_value = {16'd0, sel_half};
            default: load_value = mem_read_data;
        endcase

        store_merge = mem_read_data;
        case (lat_funct3)
            3'b000:  store_merge[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
            3'b001:  store_merge[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default: store_merge = lat_wdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-state outputs. The write enable is gated with rst_n
    // so that a reset edge taken while in WRITE never commits the store.
    always_comb begin
        next_state     = state;
        ready_int      = 1'b0;
        resp_valid_int = 1'b0;
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        mem_w_en       = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (handshake) begin
                    if (req_fault) begin
                        next_state = RESP;
                    end else if (req_bypass) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                mem_address = {lat_addr[31:2], 2'b00};
                next_state  = lat_we ? WRITE : RESP;
            end
            WRITE: begin
                mem_address    = {lat_addr[31:2], 2'b00};
                mem_write_data = merged_word;
                mem_w_en       = rst_n;
                next_state     = RESP;
            end
            RESP: begin
                resp_valid_int = 1'b1;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latches and response registers. Response values only change on
    // the transition into RESP so they hold steady between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_addr       <= 32'd0;
            lat_we         <= 1'b0;
            lat_wdata      <= 32'd0;
            lat_funct3     <= 3'd0;
            merged_word    <= 32'd0;
            rdata_reg      <= 32'd0;
            misaligned_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        lat_addr   <= bus.req_addr;
                        lat_we     <= bus.req_we;
                        lat_wdata  <= bus.req_wdata;
                        lat_funct3 <= bus.req_funct3;
                        if (req_fault) begin
                            rdata_reg      <= 32'd0;
                            misaligned_reg <= 1'b1;
                        end else if (req_bypass) begin
                            merged_word <= bus.req_wdata;
                        end
                    end
                end
                READ: begin
                    if (lat_we) begin
                        merged_word <= store_merge;
                    end else begin
                        rdata_reg      <= load_value;
                        misaligned_reg <= 1'b0;
                    end
                end
                WRITE: begin
                    rdata_reg      <= 32'd0;
                    misaligned_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    // Saturating counters, bumped once per response according to its kind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_count  <= 16'd0;
            store_count <= 16'd0;
            fault_count <= 16'd0;
        end else if (state == RESP) begin
            if (misaligned_reg) begin
                if (fault_count != 16'hFFFF) fault_count <= fault_count + 16'd1;
            end else if (lat_we) begin
                if (store_count != 16'hFFFF) store_count <= store_count + 16'd1;
            end else begin
                if (load_count != 16'hFFFF) load_count <= load_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit. A small word memory model sits on
// the memory port; every request pushes its expected response (data, fault
// flag, latency) onto a scoreboard queue that a negedge monitor pops when
// resp_valid is seen. Scenario tasks add their own direct checks.
// Build with +define+LSU_STATS_EN to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_w_en;
`ifdef LSU_STATS_EN
    logic [15:0] load_count;
    logic [15:0] store_count;
    logic [15:0] fault_count;
`endif

    load_store_unit #(.BYPASS_WORD_STORE(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_w_en       (mem_w_en),
        .mem_read_data  (mem_read_data)
`ifdef LSU_STATS_EN
        ,
        .load_count     (load_count),
        .store_count    (store_count),
        .fault_count    (fault_count)
`endif
    );

    // Word memory: combinational read, synchronous write, plus a backdoor
    // preload port driven by the bench.
    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_data = 32'd0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        else if (mem_w_en) mem[mem_address[7:2]] <= mem_write_data;
    end

    assign mem_read_data = mem[mem_address[7:2]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_loads = 0;
    int n_stores = 0;
    int n_faults = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    exp_t        mon_e;
    int          mon_acc;
    int          last_acc = 0;
    int          write_cnt = 0;
    int          write_cyc = 0;
    int          resp_cnt = 0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_wdata = 32'd0;

    // Cycle counter advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records memory writes, records acceptance cycles and checks
    // every response against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_w_en) begin
                write_cnt++;
                write_cyc  = cyc;
                last_waddr = mem_address;
                last_wdata = mem_write_data;
            end
            if (bus.resp_valid) begin
                resp_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_resp rdata=%h mis=%b required=no response",
                             bus.resp_rdata, bus.resp_misaligned);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_acc = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    if (bus.resp_rdata !== mon_e.rdata) begin
                        errors++;
                        $display("[TB] FAIL %s_rdata got=%h required=%h",
                                 mon_e.name, bus.resp_rdata, mon_e.rdata);
                    end
                    checks++;
                    if (bus.resp_misaligned !== mon_e.mis) begin
                        errors++;
                        $display("[TB] FAIL %s_misaligned got=%b required=%b",
                                 mon_e.name, bus.resp_misaligned, mon_e.mis);
                    end
                    checks++;
                    if (cyc - mon_acc != mon_e.lat) begin
                        errors++;
                        $display("[TB] FAIL %s_latency got=%0d required=%0d",
                                 mon_e.name, cyc - mon_acc, mon_e.lat);
                    end
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_q.push_back(cyc);
                last_acc = cyc;
            end
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pre_en   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been seen.
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one request and wait (bounded) for it to be accepted. Called just
    // after an active edge; returns just after the acceptance edge.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3,
                                 input logic [31:0] erd, input logic emis,
                                 input int elat, input string name,
                                 input bit expect_resp, input bit hold,
                                 output int waited);
        if (expect_resp) begin
            exp_q.push_back('{rdata: erd, mis: emis, lat: elat, name: name});
            if (emis) n_faults++;
            else if (we) n_stores++;
            else n_loads++;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_funct3 = f3;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.req_ready && waited < 50);
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_accept_timeout got=not ready required=ready", name);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.req_valid = 1'b0;
            if (expect_resp) wait_drain(name);
        end
    endtask

    task automatic test_reset();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_funct3 = 3'd0;
        rst_n = 1'b0;
        preload(6'd4,  32'h8899AABB);
        preload(6'd8,  32'h00000000);
        preload(6'd9,  32'h12345678);
        preload(6'd10, 32'hCAFEF00D);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b required=1", bus.req_ready); end
        checks++;
        if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got=%b required=0", bus.resp_valid); end
        checks++;
        if (bus.resp_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata got=%h required=0", bus.resp_rdata); end
        checks++;
        if (bus.resp_misaligned !== 1'b0) begin errors++; $display("[TB] FAIL reset_misaligned got=%b required=0", bus.resp_misaligned); end
        checks++;
        if (mem_w_en !== 1'b0 || mem_address !== 32'd0 || mem_write_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mem_port got=%b/%h/%h required=0/0/0", mem_w_en, mem_address, mem_write_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads();
        int w;
        applyStimulus(1'b0, 32'h11, 32'd0, 3'b000, 32'hFFFFFFAA, 1'b0, 2, "lb_11",  1, 0, w);
        applyStimulus(1'b0, 32'h13, 32'd0, 3'b100, 32'h00000088, 1'b0, 2, "lbu_13", 1, 0, w);
        applyStimulus(1'b0, 32'h12, 32'd0, 3'b001, 32'hFFFF8899, 1'b0, 2, "lh_12",  1, 0, w);
        applyStimulus(1'b0, 32'h10, 32'd0, 3'b101, 32'h0000AABB, 1'b0, 2, "lhu_10", 1, 0, w);
        applyStimulus(1'b0, 32'h24, 32'd0, 3'b000, 32'h00000078, 1'b0, 2, "lb_24",  1, 0, w);
        applyStimulus(1'b0, 32'h26, 32'd0, 3'b001, 32'h00001234, 1'b0, 2, "lh_26",  1, 0, w);
        applyStimulus(1'b0, 32'h28, 32'd0, 3'b010, 32'hCAFEF00D, 1'b0, 2, "lw_28",  1, 0, w);
    endtask

    task automatic test_sub_word_store();
        int w;
        int w0 = write_cnt;
        applyStimulus(1'b1, 32'h11, 32'h12345677, 3'b000, 32'd0, 1'b0, 3, "sb_11", 1, 0, w);
        checks++;
        if (write_cnt - w0 != 1) begin errors++; $display("[TB] FAIL sb_write_count got=%0d required=1", write_cnt - w0); end
        checks++;
        if (last_waddr !== 32'h10) begin errors++; $display("[TB] FAIL sb_write_addr got=%h required=00000010", last_waddr); end
        checks++;
        if (last_wdata !== 32'h889977BB) begin errors++; $display("[TB] FAIL sb_write_data got=%h required=889977bb", last_wdata); end
        checks++;
        if (write_cyc - last_acc != 2) begin errors++; $display("[TB] FAIL sb_write_cycle got=%0d required=2", write_cyc - last_acc); end
        applyStimulus(1'b0, 32'h10, 32'd0, 3'b010, 32'h889977BB, 1'b0, 2, "lw_after_sb", 1, 0, w);
        applyStimulus(1'b1, 32'h26, 32'hAAAABEEF, 3'b001, 32'd0, 1'b0, 3, "sh_26", 1, 0, w);
        checks++;
        if (last_wdata !== 32'hBEEF5678) begin errors++; $display("[TB] FAIL sh_write_data got=%h required=beef5678", last_wdata); end
        applyStimulus(1'b0, 32'h24, 32'd0, 3'b010, 32'hBEEF5678, 1'b0, 2, "lw_after_sh", 1, 0, w);
    endtask

    task automatic test_faults();
        int w;
        int w0 = write_cnt;
        applyStimulus(1'b1, 32'h13, 32'hFFFF1234, 3'b001, 32'd0, 1'b1, 1, "sh_13_fault",  1, 0, w);
        applyStimulus(1'b0, 32'h12, 32'd0,        3'b010, 32'd0, 1'b1, 1, "lw_12_fault",  1, 0, w);
        applyStimulus(1'b0, 32'h10, 32'd0,        3'b011, 32'd0, 1'b1, 1, "f3_011_fault", 1, 0, w);
        applyStimulus(1'b1, 32'h20, 32'h55,       3'b100, 32'd0, 1'b1, 1, "sbu_fault",    1, 0, w);
        applyStimulus(1'b0, 32'h11, 32'd0,        3'b001, 32'd0, 1'b1, 1, "lh_11_fault",  1, 0, w);
        checks++;
        if (write_cnt != w0) begin errors++; $display("[TB] FAIL fault_writes got=%0d required=0", write_cnt - w0); end
        checks++;
        if (mem[4] !== 32'h889977BB) begin errors++; $display("[TB] FAIL fault_mem_word got=%h required=889977bb", mem[4]); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.resp_misaligned !== 1'b1) begin errors++; $display("[TB] FAIL fault_flag_hold got=%b required=1", bus.resp_misaligned); end
    endtask

    task automatic test_bypass_store();
        int w;
        applyStimulus(1'b1, 32'h20, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0, 2, "sw_20", 1, 0, w);
        checks++;
        if (write_cyc - last_acc != 1) begin errors++; $display("[TB] FAIL sw_write_cycle got=%0d required=1", write_cyc - last_acc); end
        checks++;
        if (last_waddr !== 32'h20 || last_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL sw_write got=%h/%h required=00000020/deadbeef", last_waddr, last_wdata);
        end
        applyStimulus(1'b0, 32'h20, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0, 2, "lw_after_sw", 1, 0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        int r0 = resp_cnt;
        int w0 = write_cnt;
        applyStimulus(1'b0, 32'h10, 32'd0, 3'b010, 32'h889977BB, 1'b0, 2, "b2b_0", 1, 1, w);
        applyStimulus(1'b0, 32'h20, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0, 2, "b2b_1", 1, 1, w);
        checks++;
        if (w != 3) begin errors++; $display("[TB] FAIL b2b_1_ready_wait got=%0d required=3", w); end
        applyStimulus(1'b0, 32'h24, 32'd0, 3'b010, 32'hBEEF5678, 1'b0, 2, "b2b_2", 1, 1, w);
        checks++;
        if (w != 3) begin errors++; $display("[TB] FAIL b2b_2_ready_wait got=%0d required=3", w); end
        applyStimulus(1'b0, 32'h28, 32'd0, 3'b010, 32'hCAFEF00D, 1'b0, 2, "b2b_3", 1, 0, w);
        checks++;
        if (w != 3) begin errors++; $display("[TB] FAIL b2b_3_ready_wait got=%0d required=3", w); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_cnt - r0 != 4) begin errors++; $display("[TB] FAIL b2b_resp_count got=%0d required=4", resp_cnt - r0); end
        checks++;
        if (write_cnt != w0) begin errors++; $display("[TB] FAIL b2b_writes got=%0d required=0", write_cnt - w0); end
    endtask

    task automatic test_reset_mid_op();
        int w;
        int r0 = resp_cnt;
        int w0 = write_cnt;
`ifdef LSU_STATS_EN
        checks++;
        if (load_count !== 16'(n_loads) || store_count !== 16'(n_stores) || fault_count !== 16'(n_faults)) begin
            errors++;
            $display("[TB] FAIL stats_counts got=%0d/%0d/%0d required=%0d/%0d/%0d",
                     load_count, store_count, fault_count, n_loads, n_stores, n_faults);
        end
`endif
        applyStimulus(1'b1, 32'h21, 32'h00000011, 3'b000, 32'd0, 1'b0, 3, "sb_reset", 0, 0, w);
        @(posedge clk);
        #1;
        checks++;
        if (mem_w_en !== 1'b1) begin errors++; $display("[TB] FAIL mid_op_in_write got=%b required=1", mem_w_en); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_op_wen_gated got=%b required=0", mem_w_en); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        acc_q.delete();
        checks++;
        if (resp_cnt != r0) begin errors++; $display("[TB] FAIL mid_op_resp got=%0d required=0", resp_cnt - r0); end
        checks++;
        if (write_cnt != w0 || mem[8] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL mid_op_no_write got=%0d/%h required=0/deadbeef", write_cnt - w0, mem[8]);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_op_idle got=%b required=1", bus.req_ready); end
`ifdef LSU_STATS_EN
        checks++;
        if (load_count !== 16'd0 || store_count !== 16'd0 || fault_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL stats_reset got=%0d/%0d/%0d required=0/0/0", load_count, store_count, fault_count);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    // Main sequence.
    initial begin
        test_reset();
        test_loads();
        test_sub_word_store();
        test_faults();
        test_bypass_store();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
